// File: rtl/sqrt_f.sv
// sqrt_f: iterative digit-by-digit square root, UQ7.24 in, UQ4.13 out, one root bit per clock.
// Optional SQRT_F_ROUND_EN selects round-to-nearest instead of truncation.
`default_nettype none

module sqrt_f (
    input  logic        clk,
    input  logic        rst,
    input  logic [30:0] e,
    input  logic        e_valid,
    output logic        e_ready,
    output logic [16:0] f,
    output logic        f_valid,
    input  logic        f_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [33:0] rad;
    logic [16:0] q;
    logic [18:0] rem;
    logic [4:0]  cnt;

    logic [20:0] shifted;
    logic [21:0] trial;
    logic        take;
    logic [16:0] q_next;
    logic [18:0] rem_next;
    logic [16:0] f_load;

    always_comb begin
        shifted  = {rem, rad[33:32]};
        trial    = {1'b0, shifted} - {3'b000, q, 2'b01};
        take     = ~trial[21];
        q_next   = {q[15:0], take};
        // Remainder never exceeds 2*q, so 19 bits always hold it.
        rem_next = take ? trial[18:0] : shifted[18:0];
    end

`ifdef SQRT_F_ROUND_EN
    logic round_up;
    always_comb begin
        round_up = rem_next > {2'b00, q_next};
        if (round_up && (q_next != 17'h1FFFF))
            f_load = q_next + 17'd1;
        else
            f_load = q_next;
    end
`else
    assign f_load = q_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            e_ready <= 1'b1;
            f_valid <= 1'b0;
            f       <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            rad     <= '0;
            q       <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (e_valid) begin
                        rad     <= {1'b0, e, 2'b00};
                        q       <= '0;
                        rem     <= '0;
                        cnt     <= 5'd16;
                        state   <= CALC;
                        e_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    rad <= {rad[31:0], 2'b00};
                    q   <= q_next;
                    rem <= rem_next;
                    if (cnt == 5'd0) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        f_valid <= 1'b1;
                        f       <= f_load;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    if (f_ready) begin
                        state   <= IDLE;
                        f_valid <= 1'b0;
                        e_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    e_ready <= 1'b1;
                    f_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sqrt_f.sv
// tb_sqrt_f: directed and randomized self-checking bench for sqrt_f.
`default_nettype none

module tb_sqrt_f;

    logic        clk;
    logic        rst;
    logic [30:0] e;
    logic        e_valid;
    logic        e_ready;
    logic [16:0] f;
    logic        f_valid;
    logic        f_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sqrt_f dut (
        .clk     (clk),
        .rst     (rst),
        .e       (e),
        .e_valid (e_valid),
        .e_ready (e_ready),
        .f       (f),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: floor(sqrt(4e)) with optional round-to-nearest.
    function automatic logic [16:0] golden(input logic [30:0] v);
        longint r, s, rm;
        r = {31'd0, v, 2'b00};
        s = longint'($floor($sqrt(real'(r))));
        while (s * s > r) s--;
        while ((s + 1) * (s + 1) <= r) s++;
        rm = r - s * s;
`ifdef SQRT_F_ROUND_EN
        if (rm > s && s != 64'h1FFFF) s++;
`endif
        return s[16:0];
    endfunction

    // One transaction; all driving happens 1ns after a rising edge.
    task automatic do_op(input string tag, input logic [30:0] val, input logic [16:0] exp,
                         input int stall, input bit hold);
        int n;
        e       = val;
        e_valid = 1'b1;
        f_ready = (stall == 0);
        check({tag, "_rdy"}, e_ready, 1'b1);
        @(posedge clk); #1;
        if (!hold) e_valid = 1'b0;
        n = 0;
        while (!f_valid && n < 40) begin
            if (hold) e = 31'($urandom);
            @(posedge clk); #1;
            n++;
        end
        e_valid = 1'b0;
        check({tag, "_lat"}, n, 17);
        check({tag, "_f"}, f, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {f_valid, e_ready, f}, {1'b1, 1'b0, exp});
        end
        f_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_cons"}, {f_valid, e_ready}, 2'b01);
    endtask

    initial begin
        logic [30:0] v;
        rst     = 1'b0;
        e       = '0;
        e_valid = 1'b0;
        f_ready = 1'b0;
        #12;
        check("rst_vals", {e_ready, f_valid, busy, f}, {3'b100, 17'h0});
        rst = 1'b1;
        @(posedge clk); #1;

        do_op("four",  31'h0400_0000, 17'h04000, 0, 1'b0);
        do_op("two",   31'h0200_0000, 17'h02D41, 0, 1'b0);
`ifdef SQRT_F_ROUND_EN
        do_op("max",   31'h7FFF_FFFF, 17'h16A0A, 0, 1'b0);
`else
        do_op("max",   31'h7FFF_FFFF, 17'h16A09, 0, 1'b0);
`endif
        do_op("zero",  31'h0,         17'h00000, 0, 1'b1);
        do_op("bp",    31'h0200_0000, 17'h02D41, 10, 1'b0);

        // Reset in the middle of the iteration.
        e       = 31'h7FFF_FFFF;
        e_valid = 1'b1;
        @(posedge clk); #1;
        e_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        check("mid_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst", {e_ready, f_valid, busy, f}, {3'b100, 17'h0});
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        do_op("post",  31'h0400_0000, 17'h04000, 0, 1'b0);

        do_op("one",   31'h0000_0001, golden(31'h1), 0, 1'b0);
        do_op("three", 31'h0000_0003, golden(31'h3), 1, 1'b0);

        for (int k = 0; k < 200; k++) begin
            v = 31'($urandom);
            do_op("rnd", v, golden(v), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
